// File: rtl/map_scan_ctrl.sv
// map_scan_ctrl: raster sequencer for the lower-half map renderer.
// It walks screen coordinates (0..X_MAX, Y_BASE..Y_MAX) into the renderer.
// It waits out the renderer read latency, then hands each pixel to the LCD
// driver over a valid/ready handshake.
// Map coordinates and zoom rate are latched once per frame so a frame never tears.
// Ports:
//   clk, rst                      clock, async active-low reset
//   frame_start                   one-cycle frame request (ignored unless idle)
//   zoom_in, zoom_out             one-cycle pulses stepping the pending zoom rate
//   b_map_*_in, a_map_*_in        live bicycle / mobile map coordinates
//   disp_data_in                  RGB565 pixel from the renderer
//   pix_ready                     LCD driver accepts pix_data
//   pixel_x, pixel_y              screen coordinate to the renderer
//   b_map_*, a_map_*, rate        frame-latched renderer controls
//   pix_data, pix_valid           pixel handshake to the LCD driver
//   busy, frame_done              frame in progress / end-of-frame pulse
module map_scan_ctrl #(
  parameter int unsigned MAP_LAT   = 1,
  parameter logic [1:0]  RATE_INIT = 2'b00,
  parameter int unsigned X_MAX     = 319,
  parameter int unsigned Y_BASE    = 240,
  parameter int unsigned Y_MAX     = 479,
  localparam int unsigned CW       = 9,
  localparam int unsigned DW       = 16,
  localparam int unsigned RW       = 2
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          frame_start,
  input  logic          zoom_in,
  input  logic          zoom_out,
  input  logic [CW-1:0] b_map_x_in,
  input  logic [CW-1:0] b_map_y_in,
  input  logic [CW-1:0] a_map_x_in,
  input  logic [CW-1:0] a_map_y_in,
  input  logic [DW-1:0] disp_data_in,
  input  logic          pix_ready,
  output logic [CW-1:0] pixel_x,
  output logic [CW-1:0] pixel_y,
  output logic [CW-1:0] b_map_x,
  output logic [CW-1:0] b_map_y,
  output logic [CW-1:0] a_map_x,
  output logic [CW-1:0] a_map_y,
  output logic [RW-1:0] rate,
  output logic [DW-1:0] pix_data,
  output logic          pix_valid,
  output logic          busy,
  output logic          frame_done
);

  localparam int unsigned CNT_W = 3;

  typedef enum logic [2:0] {IDLE, ISSUE, WAIT, OUT, DONE} state_t;

  state_t            state, state_nxt;
  logic [CNT_W-1:0]  cnt, cnt_nxt;
  logic [RW-1:0]     rate_pending, rate_pending_nxt;
  logic [CW-1:0]     pixel_x_nxt, pixel_y_nxt;
  logic [CW-1:0]     b_map_x_nxt, b_map_y_nxt, a_map_x_nxt, a_map_y_nxt;
  logic [RW-1:0]     rate_nxt;
  logic [DW-1:0]     pix_data_nxt;
  logic              pix_valid_nxt, busy_nxt, frame_done_nxt;
  logic              last_pix;

  assign last_pix = (pixel_x == CW'(X_MAX)) && (pixel_y == CW'(Y_MAX));

  // State and registered outputs
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state        <= IDLE;
      cnt          <= '0;
      rate_pending <= RATE_INIT;
      pixel_x      <= '0;
      pixel_y      <= CW'(Y_BASE);
      b_map_x      <= '0;
      b_map_y      <= '0;
      a_map_x      <= '0;
      a_map_y      <= '0;
      rate         <= RATE_INIT;
      pix_data     <= '0;
      pix_valid    <= 1'b0;
      busy         <= 1'b0;
      frame_done   <= 1'b0;
    end else begin
      state        <= state_nxt;
      cnt          <= cnt_nxt;
      rate_pending <= rate_pending_nxt;
      pixel_x      <= pixel_x_nxt;
      pixel_y      <= pixel_y_nxt;
      b_map_x      <= b_map_x_nxt;
      b_map_y      <= b_map_y_nxt;
      a_map_x      <= a_map_x_nxt;
      a_map_y      <= a_map_y_nxt;
      rate         <= rate_nxt;
      pix_data     <= pix_data_nxt;
      pix_valid    <= pix_valid_nxt;
      busy         <= busy_nxt;
      frame_done   <= frame_done_nxt;
    end
  end

  // Next-state logic
  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE:    if (frame_start) state_nxt = ISSUE;
      ISSUE:   state_nxt = WAIT;
      WAIT:    if (cnt == CNT_W'(1)) state_nxt = OUT;
      // pix_valid is always high in OUT, so pix_ready alone completes the handshake
      OUT:     if (pix_ready) state_nxt = last_pix ? DONE : ISSUE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Next values of the datapath and output registers
  always_comb begin
    cnt_nxt          = cnt;
    rate_pending_nxt = rate_pending;
    pixel_x_nxt      = pixel_x;
    pixel_y_nxt      = pixel_y;
    b_map_x_nxt      = b_map_x;
    b_map_y_nxt      = b_map_y;
    a_map_x_nxt      = a_map_x;
    a_map_y_nxt      = a_map_y;
    rate_nxt         = rate;
    pix_data_nxt     = pix_data;
    pix_valid_nxt    = pix_valid;
    busy_nxt         = (state_nxt != IDLE);
    frame_done_nxt   = (state_nxt == DONE);

    // Zoom steps in any state; simultaneous in+out cancel
    unique case ({zoom_in, zoom_out})
      2'b10:   if (rate_pending != RW'(3)) rate_pending_nxt = rate_pending + RW'(1);
      2'b01:   if (rate_pending != RW'(0)) rate_pending_nxt = rate_pending - RW'(1);
      default: rate_pending_nxt = rate_pending;
    endcase

    unique case (state)
      IDLE: begin
        if (frame_start) begin
          // rate takes the pending value from before any same-cycle zoom pulse
          b_map_x_nxt = b_map_x_in;
          b_map_y_nxt = b_map_y_in;
          a_map_x_nxt = a_map_x_in;
          a_map_y_nxt = a_map_y_in;
          rate_nxt    = rate_pending;
          pixel_x_nxt = '0;
          pixel_y_nxt = CW'(Y_BASE);
        end
      end
      ISSUE: cnt_nxt = CNT_W'(MAP_LAT);
      WAIT: begin
        cnt_nxt = cnt - CNT_W'(1);
        if (cnt == CNT_W'(1)) begin
          pix_data_nxt  = disp_data_in;
          pix_valid_nxt = 1'b1;
        end
      end
      OUT: begin
        if (pix_ready) begin
          pix_valid_nxt = 1'b0;
          if (!last_pix) begin
            if (pixel_x != CW'(X_MAX)) begin
              pixel_x_nxt = pixel_x + CW'(1);
            end else begin
              pixel_x_nxt = '0;
              pixel_y_nxt = pixel_y + CW'(1);
            end
          end
        end
      end
      DONE: begin
        pixel_x_nxt = '0;
        pixel_y_nxt = CW'(Y_BASE);
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_map_scan_ctrl.sv
// Directed bench for map_scan_ctrl with a one-cycle renderer model.
// The region is narrowed (X_MAX=103, Y_MAX=301) so three frames stay short.
// The narrowed region still contains pixels (5,240) and (100,300).
`timescale 1ns/1ps
module tb_map_scan_ctrl;

  localparam int unsigned MAP_LAT   = 1;
  localparam int unsigned X_MAX     = 103;
  localparam int unsigned Y_BASE    = 240;
  localparam int unsigned Y_MAX     = 301;
  localparam int unsigned FRAME_PIX = (X_MAX + 1) * (Y_MAX - Y_BASE + 1);
  localparam int unsigned TIMEOUT   = 30000;

  logic        clk = 1'b0;
  logic        rst;
  logic        frame_start, zoom_in, zoom_out, pix_ready;
  logic [8:0]  b_map_x_in, b_map_y_in, a_map_x_in, a_map_y_in;
  logic [15:0] disp_data_in = '0;
  logic [8:0]  pixel_x, pixel_y, b_map_x, b_map_y, a_map_x, a_map_y;
  logic [1:0]  rate;
  logic [15:0] pix_data;
  logic        pix_valid, busy, frame_done;

  int checks = 0;
  int failures = 0;
  int cyc = 0;

  map_scan_ctrl #(
    .MAP_LAT(MAP_LAT), .RATE_INIT(2'b00), .X_MAX(X_MAX), .Y_BASE(Y_BASE), .Y_MAX(Y_MAX)
  ) dut (
    .clk(clk), .rst(rst), .frame_start(frame_start), .zoom_in(zoom_in), .zoom_out(zoom_out),
    .b_map_x_in(b_map_x_in), .b_map_y_in(b_map_y_in), .a_map_x_in(a_map_x_in), .a_map_y_in(a_map_y_in),
    .disp_data_in(disp_data_in), .pix_ready(pix_ready),
    .pixel_x(pixel_x), .pixel_y(pixel_y), .b_map_x(b_map_x), .b_map_y(b_map_y),
    .a_map_x(a_map_x), .a_map_y(a_map_y), .rate(rate), .pix_data(pix_data),
    .pix_valid(pix_valid), .busy(busy), .frame_done(frame_done)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Renderer model: one registered stage, pixel value encodes its coordinate
  always @(posedge clk) disp_data_in <= {pixel_y[6:0], pixel_x};

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at t=%0t", tag, obs, exp, $time);
    end
  endtask

  // Accepted-pixel monitor: raster order, data, spacing, frame length
  logic [8:0] ex, ey;
  int  n_acc = 0;
  int  n_done = 0;
  int  last_acc = 0;
  bit  spacing_en = 1'b0;

  always @(negedge clk) begin
    if (!busy) begin
      ex = 9'd0;
      ey = 9'(Y_BASE);
      n_acc = 0;
    end else begin
      if (pix_valid && pix_ready) begin
        check("pix_data", 32'(pix_data), 32'({ey[6:0], ex}));
        check("pix_xy", 32'({pixel_y, pixel_x}), 32'({ey, ex}));
        if (spacing_en && n_acc > 0) check("pix_spacing", 32'(cyc - last_acc), MAP_LAT + 2);
        last_acc = cyc;
        n_acc++;
        if (ex == 9'(X_MAX)) begin
          ex = 9'd0;
          ey = ey + 9'd1;
        end else begin
          ex = ex + 9'd1;
        end
      end
      if (frame_done) begin
        n_done++;
        check("frame_len", 32'(n_acc), FRAME_PIX);
      end
    end
  end

  task automatic pulse(input logic fs, input logic zi, input logic zo);
    @(posedge clk); #1;
    frame_start = fs; zoom_in = zi; zoom_out = zo;
    @(posedge clk); #1;
    frame_start = 1'b0; zoom_in = 1'b0; zoom_out = 1'b0;
  endtask

  task automatic wait_xy(input logic [8:0] x, input logic [8:0] y);
    bit found = 1'b0;
    for (int k = 0; k < TIMEOUT && !found; k++) begin
      @(negedge clk);
      if (pixel_x == x && pixel_y == y) found = 1'b1;
    end
    check("wait_xy_reached", 32'(found), 32'd1);
  endtask

  task automatic wait_done(input int target);
    for (int k = 0; k < TIMEOUT && n_done < target; k++) @(negedge clk);
    check("frame_done_cnt", 32'(n_done), 32'(target));
    @(negedge clk);
    check("post_done_busy", 32'(busy), 32'd0);
    check("post_done_pulse", 32'(frame_done), 32'd0);
    check("post_done_y", 32'(pixel_y), Y_BASE);
    check("post_done_done_cnt", 32'(n_done), 32'(target));
  endtask

  logic [8:0]  yb;
  logic [15:0] bp_exp;

  initial begin
    rst = 1'b1;
    frame_start = 1'b0; zoom_in = 1'b0; zoom_out = 1'b0; pix_ready = 1'b1;
    b_map_x_in = 9'd11; b_map_y_in = 9'd22; a_map_x_in = 9'd10; a_map_y_in = 9'd33;
    #2 rst = 1'b0;
    #1;
    check("rst_pixel_y", 32'(pixel_y), Y_BASE);
    check("rst_pix_valid", 32'(pix_valid), 32'd0);
    repeat (3) @(posedge clk);
    #1 rst = 1'b1;

    // Idle after reset with no stimulus
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      check("idle_pixel_y", 32'(pixel_y), Y_BASE);
      check("idle_pixel_x", 32'(pixel_x), 32'd0);
      check("idle_rate", 32'(rate), 32'd0);
      check("idle_pix_valid", 32'(pix_valid), 32'd0);
      check("idle_busy", 32'(busy), 32'd0);
    end

    // 4 zoom_in saturate pending at 3; zoom_out with frame_start is not seen by frame 1
    repeat (4) pulse(1'b0, 1'b1, 1'b0);
    check("rate_before_frame", 32'(rate), 32'd0);
    @(posedge clk); #1;
    frame_start = 1'b1; zoom_out = 1'b1;
    @(posedge clk); #1;
    frame_start = 1'b0; zoom_out = 1'b0;
    spacing_en = 1'b1;
    @(negedge clk);
    check("f1_busy", 32'(busy), 32'd1);
    check("f1_rate", 32'(rate), 32'd3);
    check("f1_b_map_x", 32'(b_map_x), 32'd11);
    check("f1_b_map_y", 32'(b_map_y), 32'd22);
    check("f1_a_map_x", 32'(a_map_x), 32'd10);
    check("f1_a_map_y", 32'(a_map_y), 32'd33);

    // frame_start while busy must be ignored
    repeat (300) @(posedge clk);
    pulse(1'b1, 1'b0, 1'b0);
    wait_done(1);
    spacing_en = 1'b0;

    // Frame 2: backpressure, mid-frame input and zoom changes
    pulse(1'b1, 1'b0, 1'b0);
    @(negedge clk);
    check("f2_rate", 32'(rate), 32'd2);
    check("f2_a_map_x", 32'(a_map_x), 32'd10);
    wait_xy(9'd5, 9'(Y_BASE));
    @(posedge clk); #1 pix_ready = 1'b0;
    @(negedge clk);
    yb = 9'(Y_BASE);
    bp_exp = {yb[6:0], 9'd5};
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      check("bp_valid", 32'(pix_valid), 32'd1);
      check("bp_data", 32'(pix_data), 32'(bp_exp));
      check("bp_x", 32'(pixel_x), 32'd5);
    end
    @(posedge clk); #1 pix_ready = 1'b1;
    wait_xy(9'd6, 9'(Y_BASE));

    a_map_x_in = 9'd50;
    repeat (5) pulse(1'b0, 1'b0, 1'b1);
    pulse(1'b0, 1'b1, 1'b0);
    pulse(1'b0, 1'b1, 1'b1);
    @(negedge clk);
    check("f2_a_map_x_held", 32'(a_map_x), 32'd10);
    check("f2_rate_held", 32'(rate), 32'd2);
    wait_done(2);

    // Frame 3: new latched values, then reset mid-frame at (100,300)
    pulse(1'b1, 1'b0, 1'b0);
    @(negedge clk);
    check("f3_rate", 32'(rate), 32'd1);
    check("f3_a_map_x", 32'(a_map_x), 32'd50);
    wait_xy(9'd100, 9'd300);
    #2 rst = 1'b0;
    #1;
    check("mrst_pixel_x", 32'(pixel_x), 32'd0);
    check("mrst_pixel_y", 32'(pixel_y), Y_BASE);
    check("mrst_coords", 32'({b_map_x, b_map_y, a_map_x[8:0]}), 32'd0);
    check("mrst_a_map_y", 32'(a_map_y), 32'd0);
    check("mrst_rate", 32'(rate), 32'd0);
    check("mrst_pix_data", 32'(pix_data), 32'd0);
    check("mrst_pix_valid", 32'(pix_valid), 32'd0);
    check("mrst_busy", 32'(busy), 32'd0);
    check("mrst_frame_done", 32'(frame_done), 32'd0);
    repeat (3) @(posedge clk);
    #1 rst = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      check("after_rst_busy", 32'(busy), 32'd0);
      check("after_rst_done", 32'(frame_done), 32'd0);
    end
    check("total_frame_done", 32'(n_done), 32'd2);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
